// File: rtl/pll_scan_loader.sv
// pll_scan_loader
//   Responder side of the PLL reconfiguration handshake. A write_from_rom
//   strobe copies a CHAIN_LEN-bit image out of a 1-bit-wide ROM into an
//   internal cache. A reconfig strobe shifts that cache into the PLL scan
//   chain (MSB first), pulses configupdate for two cycles and waits for a
//   rising edge of scandone. A missing scandone sets the sticky timeout_err.
//   A synchronous soft reset aborts any operation and keeps the cache.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   write_from_rom, reconfig     1-cycle request strobes (sampled in IDLE)
//   reset                        synchronous soft abort
//   busy, timeout_err            status back to the requester
//   rom_address_out, write_rom_ena, rom_data_in   ROM read port (1-cycle q)
//   pll_scanclk, pll_scanclkena, pll_scandata, pll_scandataout,
//   pll_configupdate, pll_scandone                PLL reconfig port
//
// Build option
//   PLL_SCAN_READBACK_EN: while shifting, capture pll_scandataout on each
//   scanclk rise and replace the cache with the image read out of the PLL.
module pll_scan_loader #(
  parameter int CHAIN_LEN    = 144,
  parameter int ADDR_W       = 8,
  parameter int DONE_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_from_rom,
  input  logic              reconfig,
  input  logic              reset,
  output logic              busy,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] rom_address_out,
  output logic              write_rom_ena,
  input  logic              rom_data_in,
  output logic              pll_scanclk,
  output logic              pll_scanclkena,
  output logic              pll_scandata,
  input  logic              pll_scandataout,
  output logic              pll_configupdate,
  input  logic              pll_scandone
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int CW = (TW > ADDR_W) ? TW : ADDR_W;

  typedef enum logic [2:0] {IDLE, ROM_RD, SHIFT, UPDATE, WAIT_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   tmo_q, tmo_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic                   rom_ena_q, rom_ena_d;
  logic [ADDR_W-1:0]      cap_addr_q, cap_addr_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [CHAIN_LEN-1:0]   cache_q, cache_d;
  logic [CHAIN_LEN-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   sclkena_q, sclkena_d;
  logic                   sdata_q, sdata_d;
  logic                   cfgupd_q, cfgupd_d;
  logic [1:0]             done_sync_q, done_sync_d;
  logic                   done_prev_q, done_prev_d;
  logic                   done_rise;
  logic                   shift_in;
  logic                   unused_shreg_msb;

`ifdef PLL_SCAN_READBACK_EN
  logic rb_q, rb_d;
  assign shift_in = rb_q;
`else
  logic unused_scandataout;
  assign unused_scandataout = pll_scandataout;
  assign shift_in           = 1'b0;
`endif

  // The shift copy's MSB is already on pll_scandata when it would be consumed.
  assign unused_shreg_msb = shreg_q[CHAIN_LEN-1];

  // scandone is asynchronous to clk; only a fresh rising edge counts.
  assign done_rise = done_sync_q[1] & ~done_prev_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rom_addr_d  = rom_addr_q;
    rom_ena_d   = rom_ena_q;
    // ROM q lags the enable by one cycle; capture uses the delayed address.
    rd_vld_d    = rom_ena_q;
    cap_addr_d  = rom_addr_q;
    cache_d     = cache_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    sclk_d      = sclk_q;
    sclkena_d   = sclkena_q;
    sdata_d     = sdata_q;
    cfgupd_d    = cfgupd_q;
    done_sync_d = {done_sync_q[0], pll_scandone};
    done_prev_d = done_sync_q[1];
`ifdef PLL_SCAN_READBACK_EN
    rb_d        = rb_q;
`endif

    if (rd_vld_q && !reset) cache_d[cap_addr_q] = rom_data_in;

    if (reset) begin
      state_d    = IDLE;
      rom_ena_d  = 1'b0;
      rom_addr_d = '0;
      rd_vld_d   = 1'b0;
      sclk_d     = 1'b0;
      sclkena_d  = 1'b0;
      sdata_d    = 1'b0;
      cfgupd_d   = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_from_rom) begin
            state_d    = ROM_RD;
            rom_ena_d  = 1'b1;
            rom_addr_d = '0;
            tmo_d      = 1'b0;
          end else if (reconfig) begin
            state_d   = SHIFT;
            sclkena_d = 1'b1;
            sclk_d    = 1'b0;
            sdata_d   = cache_q[CHAIN_LEN-1];
            shreg_d   = cache_q;
            cnt_d     = '0;
            tmo_d     = 1'b0;
          end
        end
        ROM_RD: begin
          // One extra cycle after the last enable lets the final bit land.
          if (rom_ena_q) begin
            if (rom_addr_q == ADDR_W'(CHAIN_LEN - 1)) begin
              rom_ena_d  = 1'b0;
              rom_addr_d = '0;
            end else begin
              rom_addr_d = rom_addr_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
`ifdef PLL_SCAN_READBACK_EN
            rb_d   = pll_scandataout;
`endif
          end else begin
            // Falling scanclk: advance to the next bit while the clock is low.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[CHAIN_LEN-2:0], shift_in};
            if (cnt_q == CW'(CHAIN_LEN - 1)) begin
              state_d   = UPDATE;
              sclkena_d = 1'b0;
              sdata_d   = 1'b0;
              cfgupd_d  = 1'b1;
              cnt_d     = '0;
`ifdef PLL_SCAN_READBACK_EN
              cache_d   = {shreg_q[CHAIN_LEN-2:0], shift_in};
`endif
            end else begin
              cnt_d   = cnt_q + 1'b1;
              sdata_d = shreg_q[CHAIN_LEN-2];
            end
          end
        end
        UPDATE: begin
          if (cnt_q == '0) begin
            cnt_d = CW'(1);
          end else begin
            state_d  = WAIT_DONE;
            cfgupd_d = 1'b0;
            cnt_d    = '0;
          end
        end
        WAIT_DONE: begin
          if (done_rise) begin
            state_d = IDLE;
          end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      rom_addr_q  <= '0;
      rom_ena_q   <= 1'b0;
      cap_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      cache_q     <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      sclk_q      <= 1'b0;
      sclkena_q   <= 1'b0;
      sdata_q     <= 1'b0;
      cfgupd_q    <= 1'b0;
      done_sync_q <= '0;
      done_prev_q <= 1'b0;
`ifdef PLL_SCAN_READBACK_EN
      rb_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      rom_addr_q  <= rom_addr_d;
      rom_ena_q   <= rom_ena_d;
      cap_addr_q  <= cap_addr_d;
      rd_vld_q    <= rd_vld_d;
      cache_q     <= cache_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sclk_q      <= sclk_d;
      sclkena_q   <= sclkena_d;
      sdata_q     <= sdata_d;
      cfgupd_q    <= cfgupd_d;
      done_sync_q <= done_sync_d;
      done_prev_q <= done_prev_d;
`ifdef PLL_SCAN_READBACK_EN
      rb_q        <= rb_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign timeout_err      = tmo_q;
  assign rom_address_out  = rom_addr_q;
  assign write_rom_ena    = rom_ena_q;
  assign pll_scanclk      = sclk_q;
  assign pll_scanclkena   = sclkena_q;
  assign pll_scandata     = sdata_q;
  assign pll_configupdate = cfgupd_q;
endmodule
